// File: rtl/inst_fetch.sv
// inst_fetch: RV32I instruction fetch stage.
// Assembles each instruction from four byte reads and hands it to decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_flag,
    input  logic [31:0] new_addr,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic        mem_busy,
    input  logic [7:0]  mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] addr_out
);

    localparam logic [1:0] ISSUE   = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  req_cnt_q, req_cnt_d;
    logic        pend_q, pend_d;
    logic [2:0]  rcv_cnt_q, rcv_cnt_d;
    logic [31:0] buf_q, buf_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic        accept;

    // Request port: raised only while issuing, never during reset.
    always_comb begin
        mem_re   = (state_q == ISSUE) & ~rst;
        mem_addr = pc_q + {29'd0, req_cnt_q};
        accept   = mem_re & ~mem_busy;
    end

    assign inst_valid = valid_q;
    assign inst_out   = inst_q;
    assign addr_out   = addr_q;

    // Next-state: request counting, byte capture and FSM sequencing.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_cnt_d = req_cnt_q;
        pend_d    = accept;
        rcv_cnt_d = rcv_cnt_q;
        buf_d     = buf_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        addr_d    = addr_q;

        if (accept) begin
            req_cnt_d = req_cnt_q + 3'd1;
        end

        // Byte lands the cycle after its request; busy does not matter here.
        if (pend_q) begin
            buf_d[{rcv_cnt_q[1:0], 3'b000} +: 8] = mem_rdata;
            rcv_cnt_d = rcv_cnt_q + 3'd1;
        end

        case (state_q)
            ISSUE: begin
                if (accept && req_cnt_q == 3'd3) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last byte goes straight into the output word.
                if (pend_q && rcv_cnt_q == 3'd3) begin
                    valid_d = 1'b1;
                    inst_d  = {mem_rdata, buf_q[23:0]};
                    addr_d  = pc_q;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (!stall_in) begin
                    pc_d      = branch_flag ? new_addr : pc_q + 32'd4;
                    valid_d   = 1'b0;
                    inst_d    = 32'd0;
                    addr_d    = 32'd0;
                    req_cnt_d = 3'd0;
                    rcv_cnt_d = 3'd0;
                    state_d   = ISSUE;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ISSUE;
            pc_q      <= RESET_PC;
            req_cnt_q <= 3'd0;
            pend_q    <= 1'b0;
            rcv_cnt_q <= 3'd0;
            buf_q     <= 32'd0;
            valid_q   <= 1'b0;
            inst_q    <= 32'd0;
            addr_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_cnt_q <= req_cnt_d;
            pend_q    <= pend_d;
            rcv_cnt_q <= rcv_cnt_d;
            buf_q     <= buf_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            addr_q    <= addr_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus random traffic on two instances
// (reset PC 0 and reset PC at the top of the address space).
module tb_inst_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall_in, branch_flag, mem_busy;
    logic [31:0] new_addr;
    logic        mem_re     [2];
    logic [31:0] mem_addr   [2];
    logic [7:0]  mem_rdata  [2];
    logic        inst_valid [2];
    logic [31:0] inst_out   [2];
    logic [31:0] addr_out   [2];

    inst_fetch #(.RESET_PC(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .branch_flag(branch_flag), .new_addr(new_addr),
        .mem_re(mem_re[0]), .mem_addr(mem_addr[0]),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata[0]),
        .inst_valid(inst_valid[0]), .inst_out(inst_out[0]),
        .addr_out(addr_out[0])
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .branch_flag(branch_flag), .new_addr(new_addr),
        .mem_re(mem_re[1]), .mem_addr(mem_addr[1]),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata[1]),
        .inst_valid(inst_valid[1]), .inst_out(inst_out[1]),
        .addr_out(addr_out[1])
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: fetch progress as accepted-request count plus phase.
    logic [31:0] m_pc   [2];
    int          m_nacc [2];
    bit          m_drain[2];
    bit          m_val  [2];
    logic [31:0] m_vpc  [2];
    bit          rsp_p  [2];
    logic [31:0] rsp_a  [2];

    logic        o_re   [2];
    logic [31:0] o_addr [2];
    logic        o_val  [2];
    logic [31:0] o_inst [2];
    logic [31:0] o_aout [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_at(input logic [31:0] a);
        if (a < 32'd4) begin
            case (a[1:0])
                2'd0: return 8'h13;
                2'd1: return 8'h05;
                2'd2: return 8'h10;
                default: return 8'h00;
            endcase
        end
        return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {mem_at(a + 32'd3), mem_at(a + 32'd2),
                mem_at(a + 32'd1), mem_at(a)};
    endfunction

    function automatic logic [31:0] rp(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]    = rp(i);
            m_nacc[i]  = 0;
            m_drain[i] = 1'b0;
            m_val[i]   = 1'b0;
            m_vpc[i]   = 32'd0;
        end
    endtask

    // One clock cycle: drive, check against model, advance model.
    task automatic step(input logic r, input logic b, input logic s,
                        input logic br, input logic [31:0] na);
        @(negedge clk);
        rst = r; mem_busy = b; stall_in = s;
        branch_flag = br; new_addr = na;
        for (int i = 0; i < 2; i++)
            mem_rdata[i] = rsp_p[i] ? mem_at(rsp_a[i]) : 8'($urandom);
        #1;
        for (int i = 0; i < 2; i++) begin
            bit          issuing;
            bit          e_re;
            logic [31:0] e_addr;
            issuing = !m_val[i] && !m_drain[i];
            e_re    = !r && issuing;
            e_addr  = m_pc[i] + 32'(m_nacc[i]);
            o_re[i] = mem_re[i];   o_addr[i] = mem_addr[i];
            o_val[i] = inst_valid[i];
            o_inst[i] = inst_out[i]; o_aout[i] = addr_out[i];
            chk($sformatf("mem_re%0d", i), 32'(mem_re[i]), 32'(e_re));
            if (issuing)
                chk($sformatf("mem_addr%0d", i), mem_addr[i], e_addr);
            chk($sformatf("valid%0d", i), 32'(inst_valid[i]),
                32'(m_val[i]));
            chk($sformatf("inst%0d", i), inst_out[i],
                m_val[i] ? word(m_vpc[i]) : 32'd0);
            chk($sformatf("addr_out%0d", i), addr_out[i],
                m_val[i] ? m_vpc[i] : 32'd0);
            rsp_p[i] = e_re && !b;
            rsp_a[i] = e_addr;
            if (r) begin
                m_pc[i] = rp(i); m_nacc[i] = 0;
                m_drain[i] = 1'b0; m_val[i] = 1'b0;
            end else if (m_val[i]) begin
                if (!s) begin
                    m_pc[i]   = br ? na : m_pc[i] + 32'd4;
                    m_val[i]  = 1'b0;
                    m_nacc[i] = 0;
                end
            end else if (m_drain[i]) begin
                m_val[i]   = 1'b1;
                m_vpc[i]   = m_pc[i];
                m_drain[i] = 1'b0;
            end else if (!b) begin
                m_nacc[i]++;
                if (m_nacc[i] == 4) m_drain[i] = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; mem_busy = 1'b0; stall_in = 1'b0;
        branch_flag = 1'b0; new_addr = 32'd0;
        mem_rdata[0] = 8'd0; mem_rdata[1] = 8'd0;
        rsp_p[0] = 1'b0; rsp_p[1] = 1'b0;
        rsp_a[0] = 32'd0; rsp_a[1] = 32'd0;
        repeat (2) @(posedge clk);
        model_reset();
        step(1, 0, 0, 0, 0);
        chk("rst_valid", 32'(o_val[0]), 32'd0);
        chk("rst_re", 32'(o_re[0]), 32'd0);

        // Basic fetch from 0, and wrap fetch on instance 1.
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 0, 0);
            if (c < 4) begin
                chk("basic_addr", o_addr[0], 32'(c));
                chk("wrap_addr", o_addr[1], 32'hFFFF_FFFC + 32'(c));
            end
            if (c == 4) chk("basic_early", 32'(o_val[0]), 32'd0);
            if (c == 5) begin
                chk("basic_inst", o_inst[0], 32'h0010_0513);
                chk("basic_pc", o_aout[0], 32'd0);
            end
        end

        // Busy insertion on the fetch at 4.
        for (int c = 0; c < 8; c++) begin
            step(0, (c == 1 || c == 2), 0, 0, 0);
            if (c == 0) begin
                chk("next_addr", o_addr[0], 32'd4);
                chk("wrap_next", o_addr[1], 32'd0);
            end
            if (c >= 1 && c <= 3) chk("busy_hold", o_addr[0], 32'd5);
            if (c == 6) chk("busy_late", 32'(o_val[0]), 32'd0);
            if (c == 7) chk("busy_inst", o_inst[0], word(32'd4));
        end

        // Stall hold on the fetch at 8; branch while stalled is ignored.
        for (int c = 0; c < 10; c++) begin
            logic s;
            s = (c >= 5 && c <= 7);
            step(0, 0, s, s, 32'h80);
            if (c >= 5 && c <= 8) begin
                chk("stall_inst", o_inst[0], word(32'd8));
                chk("stall_re", 32'(o_re[0]), 32'd0);
            end
            if (c == 9) chk("stall_next", o_addr[0], 32'hC);
        end

        // Fetch at 0xC (first cycle already taken above).
        for (int c = 1; c < 6; c++) step(0, 0, 0, 0, 0);

        // Redirect at handoff of 0x10, after a stalled cycle with branch.
        for (int c = 0; c < 7; c++) begin
            step(0, 0, (c == 5), (c >= 5), (c == 5) ? 32'h80 : 32'h40);
            if (c >= 5) chk("redir_pc", o_aout[0], 32'h10);
        end
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 0, 0);
            if (c < 4) chk("redir_addr", o_addr[0], 32'h40 + 32'(c));
        end

        // Reset in cycle 2 of the fetch at 0x44.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("mid_rst_re", 32'(o_re[0]), 32'd0);
        chk("mid_rst_valid", 32'(o_val[0]), 32'd0);
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 0, 0);
            if (c < 4) chk("refetch_addr", o_addr[0], 32'(c));
            if (c == 5) chk("refetch_inst", o_inst[0], 32'h0010_0513);
        end

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] na;
            na = ($urandom_range(0, 3) == 0)
               ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) < 2),
                 1'($urandom_range(0, 1)), na);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the RV32I core. Reads each 32-bit instruction as four little-endian byte reads from the byte-wide memory controller, then presents it with its PC to the decode stage as the IF/ID register. It takes the next-PC decision from decode (`branch_flag`, `new_addr`) in the handoff cycle, and honours the pipeline stall. Only one instruction is in flight at a time; there is no prefetch and no squash logic.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_in`  in  1  decode or later stage cannot accept an instruction this cycle.
- `branch_flag`  in  1  from decode; valid only in a handoff cycle; 1 selects `new_addr` as next PC.
- `new_addr`  in  32  next PC from decode; used only when `branch_flag`=1.
- `mem_re`  out  1  byte read request.
- `mem_addr`  out  32  byte address of the request.
- `mem_busy`  in  1  controller is serving the data port; a request raised this cycle is not accepted.
- `mem_rdata`  in  8  read byte, valid the cycle after an accepted request.
- `inst_valid`  out  1  `inst_out`/`addr_out` hold a fetched instruction.
- `inst_out`  out  32  instruction to decode; 0 when not valid, which decodes as a bubble.
- `addr_out`  out  32  PC of `inst_out`; 0 when not valid.

## Operation
- State registers:
  - `pc` (32).
  - `req_cnt` (0..4): requests accepted.
  - `pend` (1): a byte is due in the current cycle.
  - `rcv_cnt` (0..4): bytes captured.
  - `buf` (32).
  - FSM `ISSUE` / `DRAIN` / `PRESENT`.
- Request acceptance:
  - `mem_re` = (state==ISSUE) & ~rst. It is combinational.
  - `mem_addr` = `pc` + `req_cnt`, 32-bit wrapping.
  - A request is accepted when `mem_re` & ~`mem_busy`. On acceptance, `req_cnt`++ and `pend` is set for the next cycle. Otherwise `pend` is cleared.
  - A refused request holds the same address next cycle.
- Byte capture: when `pend`=1, `mem_rdata` is written to `buf[8*rcv_cnt+7 : 8*rcv_cnt]` and `rcv_cnt`++. Capture is independent of `mem_busy`.
- FSM transitions:
  - ISSUE → DRAIN when the 4th request is accepted.
  - DRAIN: no request is issued. When the 4th byte is captured, load `inst_out`=assembled word, `addr_out`=`pc`, `inst_valid`=1, and go to PRESENT.
  - PRESENT: outputs hold. When `stall_in`=0 (the handoff cycle), load `pc` ← (`branch_flag` ? `new_addr` : `pc`+4). Clear `inst_valid`, `inst_out`, `addr_out`, `req_cnt`, `rcv_cnt`. Go to ISSUE.
  - PRESENT with `stall_in`=1: hold indefinitely; `branch_flag` is ignored.
- Address rules:
  - `new_addr` is used verbatim; low bits are not forced to zero, since the memory is byte-addressed.
  - `pc`+4 wraps at 2^32.
- `stall_in` is ignored in ISSUE and DRAIN; fetch progresses regardless.

## Timing
- Reset values: `inst_valid`=0, `inst_out`=0, `addr_out`=0, `mem_re`=0 during the reset cycle, `mem_addr`=`RESET_PC`.
- Reset internals: `pc`=`RESET_PC`, `req_cnt`=`rcv_cnt`=0, `pend`=0, FSM=ISSUE.
- No-busy sequence, first cycle after reset = cycle 0:
  - Requests at cycles 0–3, addresses `pc`..`pc`+3.
  - Bytes arrive in cycles 1–4.
  - `inst_valid`=1 from cycle 5.
  - Handoff in cycle 5 gives the next request in cycle 6.
  - Minimum period is 6 cycles per instruction.
- Each cycle of `mem_busy` while in ISSUE adds exactly one cycle. Each stalled cycle in PRESENT adds one cycle.
- Reset mid-operation: everything above returns to reset values on the next edge. A byte returning in the cycle after reset is discarded, because `pend` has been cleared.
- `branch_flag` and `new_addr` are sampled only in the handoff cycle. They may be combinational from `inst_out`, so there is no loop through `mem_re` or `mem_addr`.

## Test plan
- **Basic fetch.** `RESET_PC`=0; memory bytes 0..3 = 13,05,10,00.
  - Required: `mem_addr` 0,1,2,3 in cycles 0–3.
  - Required: cycle 5 shows `inst_valid`=1, `inst_out`=32'h0010_0513, `addr_out`=0.
  - Next request in cycle 6 at address 4.
- **Busy insertion.** `mem_busy`=1 in cycles 1 and 2.
  - Required: `mem_addr`=1 held in cycles 1–3.
  - Required: `inst_valid` rises in cycle 7 with the correct word.
- **Stall hold.** `stall_in`=1 for 3 cycles from the first valid cycle.
  - Required: outputs stable for 4 cycles.
  - Required: next request only after the cycle with `stall_in`=0.
- **Redirect.** At handoff of PC 0x10, drive `branch_flag`=1, `new_addr`=0x40.
  - Required: next requests at 0x40..0x43.
  - Required: `branch_flag`=1 while stalled has no effect.
- **Reset mid-fetch.** Assert `rst` in cycle 2 of a fetch.
  - Required: `inst_valid`=0 and `mem_re`=0 during reset.
  - Required: the byte returned after reset is not captured.
  - Required: a clean refetch from `RESET_PC` gives the correct word.
- **Wrap.** `RESET_PC`=32'hFFFF_FFFC.
  - Required: addresses FFFF_FFFC..FFFF_FFFF.
  - Required: after a non-branch handoff, the next fetch is at address 0.
